pc_ctrl: RTL and testbench

Program-counter and branch control stage sitting directly downstream of the 8-bit ALU. It consumes the ALU result on branch-not-equal instructions (rslt = 1 means inA != inB) and, with decoder qualifiers, sequences the instruction address. It resolves branch targets through a small writable lookup table, provides the run/done handshake to the test harness, and counts taken branches.

---
 rtl/pc_pkg.sv | 18 +
 rtl/branch_lut.sv | 43 ++++
 rtl/pc_ctrl.sv | 115 +++++++++++
 tb/tb_pc_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter / branch control stage.
package pc_pkg;

    // Sequencer states. The numeric encoding is fixed so debug captures stay stable.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default geometry: 1K-word instruction memory, 16-entry branch-target table.
    localparam int PC_W_DEF      = 10;
    localparam int LUT_IDX_W_DEF = 4;

    // Taken-branch counter ceiling; the counter sticks here instead of wrapping.
    localparam logic [7:0] TAKEN_MAX = 8'hFF;

endpackage

// File: rtl/branch_lut.sv
// Branch-target lookup table: synchronous write, combinational read, async clear.
// A read and a write to the same index in one cycle return the old entry,
// because the read path comes straight from the registers.
module branch_lut #(
    parameter int IDX_W  = 4,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Next-state of the table: copy every entry, overwrite the addressed one on a write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Table storage; reset clears every entry to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter and branch control stage downstream of the 8-bit ALU.
// Sequences the instruction address through IDLE -> RUN -> DONE, resolves
// BNE targets through branch_lut, and counts taken branches (saturating).
// Harness handshake: start is a level request sampled every edge; fetch_en
// is high exactly while in RUN and done is high exactly while in DONE.
module pc_ctrl
    import pc_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int LUT_IDX_W  = LUT_IDX_W_DEF,
    parameter int START_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 halt,
    input  logic                 stall,
    input  logic                 branch_en,
    input  logic [LUT_IDX_W-1:0] branch_idx,
    input  logic [7:0]           alu_rslt,
    input  logic                 lut_we,
    input  logic [LUT_IDX_W-1:0] lut_waddr,
    input  logic [PC_W-1:0]      lut_wdata,
    output logic [PC_W-1:0]      pc,
    output logic                 fetch_en,
    output logic                 done,
    output logic [7:0]           taken_cnt
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic [PC_W-1:0] START_PC = START_ADDR[PC_W-1:0];

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      taken_cnt_q, taken_cnt_d;
    logic [PC_W-1:0] lut_rdata;
    logic            branch_taken;

    // Only bit 0 of the ALU result carries the BNE condition.
    logic unused_alu_bits;
    assign unused_alu_bits = ^alu_rslt[7:1];

    branch_lut #(
        .IDX_W  (LUT_IDX_W),
        .DATA_W (PC_W)
    ) u_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (lut_we),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (branch_idx),
        .rdata (lut_rdata)
    );

    assign branch_taken = branch_en & alu_rslt[0];

    // Sequencer: start restarts from any state; in RUN, stall > halt > branch > increment.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        taken_cnt_d = taken_cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    pc_d        = START_PC;
                    taken_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (start) begin
                    pc_d        = START_PC;
                    taken_cnt_d = '0;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (halt) begin
                    state_d = ST_DONE;
                end else if (branch_taken) begin
                    pc_d = lut_rdata;
                    if (taken_cnt_q != TAKEN_MAX) begin
                        taken_cnt_d = taken_cnt_q + 8'd1;
                    end
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, PC and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign pc        = pc_q;
    assign taken_cnt = taken_cnt_q;
    assign fetch_en  = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: linear stimulus, hand-computed expectations.
module tb_pc_ctrl;

    localparam int PC_W      = 10;
    localparam int LUT_IDX_W = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic                 halt;
    logic                 stall;
    logic                 branch_en;
    logic [LUT_IDX_W-1:0] branch_idx;
    logic [7:0]           alu_rslt;
    logic                 lut_we;
    logic [LUT_IDX_W-1:0] lut_waddr;
    logic [PC_W-1:0]      lut_wdata;
    logic [PC_W-1:0]      pc;
    logic                 fetch_en;
    logic                 done;
    logic [7:0]           taken_cnt;

    int n_pass;
    int n_total;

    pc_ctrl #(
        .PC_W       (PC_W),
        .LUT_IDX_W  (LUT_IDX_W),
        .START_ADDR (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .halt       (halt),
        .stall      (stall),
        .branch_en  (branch_en),
        .branch_idx (branch_idx),
        .alu_rslt   (alu_rslt),
        .lut_we     (lut_we),
        .lut_waddr  (lut_waddr),
        .lut_wdata  (lut_wdata),
        .pc         (pc),
        .fetch_en   (fetch_en),
        .done       (done),
        .taken_cnt  (taken_cnt)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // One clock: inputs set before the call are sampled at the edge; outputs settle by #1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    task automatic check_run(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
        check({tag, "_pc"}, 32'(pc), exp_pc);
        check({tag, "_cnt"}, 32'(taken_cnt), exp_cnt);
        check({tag, "_fetch"}, 32'(fetch_en), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic check_done(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
        check({tag, "_pc"}, 32'(pc), exp_pc);
        check({tag, "_cnt"}, 32'(taken_cnt), exp_cnt);
        check({tag, "_fetch"}, 32'(fetch_en), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_pc"}, 32'(pc), 32'd0);
        check({tag, "_cnt"}, 32'(taken_cnt), 32'd0);
        check({tag, "_fetch"}, 32'(fetch_en), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic set_branch(input logic en, input logic [LUT_IDX_W-1:0] idx, input logic [7:0] rslt);
        branch_en  = en;
        branch_idx = idx;
        alu_rslt   = rslt;
    endtask

    task automatic set_lut(input logic we, input logic [LUT_IDX_W-1:0] addr, input logic [PC_W-1:0] data);
        lut_we    = we;
        lut_waddr = addr;
        lut_wdata = data;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        halt    = 1'b0;
        stall   = 1'b0;
        set_branch(1'b0, '0, 8'h00);
        set_lut(1'b0, '0, '0);

        // Reset state.
        #12;
        check_idle("reset");
        step();
        rst_n = 1'b1;

        // IDLE holds without start, even with branch and increment conditions present.
        set_branch(1'b1, 4'd0, 8'h01);
        step();
        check_idle("idle_hold");
        set_branch(1'b0, 4'd0, 8'h00);

        // Start, then free-run 5 cycles: pc 0..5.
        start = 1'b1;
        step();
        start = 1'b0;
        check_run("start", 0, 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            check_run("seq", 32'(i), 0);
        end

        // Restart while writing lut[3]=0x120, run to pc=2, then a taken BNE.
        start = 1'b1;
        set_lut(1'b1, 4'd3, 10'h120);
        step();
        start = 1'b0;
        set_lut(1'b0, 4'd0, 10'h000);
        check_run("restart", 0, 0);
        step();
        step();
        check_run("at2", 2, 0);
        set_branch(1'b1, 4'd3, 8'h01);
        step();
        check_run("bne_taken", 32'h120, 1);

        // Not-taken BNE: only bit 0 counts, upper ALU bits ignored.
        set_branch(1'b1, 4'd3, 8'hFE);
        step();
        check_run("bne_not_taken", 32'h121, 1);

        // Halt together with a taken branch: halt wins, pc held.
        halt = 1'b1;
        set_branch(1'b1, 4'd3, 8'h01);
        step();
        check_done("halt", 32'h121, 1);
        halt = 1'b0;
        set_branch(1'b0, 4'd0, 8'h00);
        step();
        check_done("done_hold", 32'h121, 1);

        // Start from DONE: back to RUN, pc and counter cleared.
        start = 1'b1;
        step();
        start = 1'b0;
        check_run("done_start", 0, 0);
        step();
        check_run("pre_stall", 1, 0);

        // Stall for 3 cycles with halt and a taken branch pending: nothing moves.
        stall = 1'b1;
        halt  = 1'b1;
        set_branch(1'b1, 4'd3, 8'h01);
        for (int i = 0; i < 3; i++) begin
            step();
            check_run("stall", 1, 0);
        end
        stall = 1'b0;
        step();
        check_done("stall_release_halt", 1, 0);
        halt = 1'b0;
        set_branch(1'b0, 4'd0, 8'h00);

        // Branch to 0x3FE via lut[7], then free-run across the wrap.
        start = 1'b1;
        set_lut(1'b1, 4'd7, 10'h3FE);
        step();
        start = 1'b0;
        set_lut(1'b0, 4'd0, 10'h000);
        check_run("wrap_start", 0, 0);
        set_branch(1'b1, 4'd7, 8'h01);
        step();
        check_run("to_3fe", 32'h3FE, 1);
        set_branch(1'b0, 4'd0, 8'h00);
        step();
        check_run("pc_3ff", 32'h3FF, 1);
        step();
        check_run("pc_wrap", 32'h000, 1);

        // 300 taken branches in total: counter saturates at 255.
        set_branch(1'b1, 4'd7, 8'h01);
        for (int i = 0; i < 253; i++) begin
            step();
        end
        check_run("cnt_254", 32'h3FE, 254);
        step();
        check_run("cnt_255", 32'h3FE, 255);
        for (int i = 0; i < 46; i++) begin
            step();
        end
        check_run("cnt_sat", 32'h3FE, 255);

        // Same-cycle write and branch on lut[5]: old entry used, new one next cycle.
        set_branch(1'b0, 4'd0, 8'h00);
        set_lut(1'b1, 4'd5, 10'h0AA);
        step();
        check_run("lut5_pre", 32'h3FF, 255);
        set_lut(1'b1, 4'd5, 10'h155);
        set_branch(1'b1, 4'd5, 8'h01);
        step();
        check_run("lut5_old", 32'h0AA, 255);
        set_lut(1'b0, 4'd0, 10'h000);
        step();
        check_run("lut5_new", 32'h155, 255);

        // Async reset between edges: outputs clear without waiting for clk.
        #3;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        step();
        rst_n = 1'b1;
        set_branch(1'b0, 4'd0, 8'h00);
        step();
        check_idle("post_rst_idle");

        // Fresh start, then branch via lut[5]: table was cleared, target is 0.
        start = 1'b1;
        step();
        start = 1'b0;
        check_run("post_rst_start", 0, 0);
        set_branch(1'b1, 4'd5, 8'h01);
        step();
        check_run("lut5_cleared", 0, 1);
        set_branch(1'b0, 4'd0, 8'h00);
        step();
        check_run("post_rst_inc", 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
